// File: rtl/dsp_pkg.sv
// Shared widths, OPMODE bit positions and X/Z mux encodings for the dsp slice.
`timescale 1ns/1ps
package dsp_pkg;
   localparam int AW = 18;   // A, B, D, BCIN, BCOUT
   localparam int MW = 36;   // multiplier product
   localparam int PW = 48;   // C, PCIN, P, PCOUT

   localparam int OP_XSEL_LO  = 0;
   localparam int OP_ZSEL_LO  = 2;
   localparam int OP_PREADD   = 4;
   localparam int OP_CINSEL   = 5;
   localparam int OP_PRESUB   = 6;
   localparam int OP_POSTSUB  = 7;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11
   } xsel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } zsel_e;
endpackage

// File: rtl/dsp_reg_mux.sv
// One pipeline stage: registered (sync reset beats CE) or combinational bypass.
`timescale 1ns/1ps
module dsp_reg_mux #(
   parameter int W   = 18,
   parameter int REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (REG != 0) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst)     q <= '0;
            else if (ce) q <= d;
         end
      end else begin : g_byp
         logic unused_ctl;
         assign unused_ctl = clk ^ rst ^ ce;
         assign q = d;
      end
   endgenerate
endmodule

// File: rtl/dsp.sv
// Pre-adder / multiplier / post-adder slice with per-stage optional registers.
// Build macro DSP_CASCADE_EN enables the PCIN/BCIN/PCOUT/BCOUT cascade paths.
`timescale 1ns/1ps
module dsp
   import dsp_pkg::*;
#(
   parameter int    A0REG       = 0,
   parameter int    B0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT",
   parameter string RSTTYPE     = "SYNC"
) (
   input  logic          CLK,
   input  logic [7:0]    OPMODE,
   input  logic          CEA, CEB, CEC, CECARRYIN, CED, CEM, CEP, CEOPMODE,
   input  logic          RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTP, RSTOPMODE,
   input  logic [AW-1:0] A,
   input  logic [AW-1:0] B,
   input  logic [AW-1:0] D,
   input  logic [PW-1:0] C,
   input  logic [PW-1:0] PCIN,
   input  logic          CARRYIN,
   input  logic [AW-1:0] BCIN,
   output logic [MW-1:0] M,
   output logic [PW-1:0] P,
   output logic [PW-1:0] PCOUT,
   output logic          CARRYOUT,
   output logic          CARRYOUTF,
   output logic [AW-1:0] BCOUT
);
   logic [7:0]    opm;
   logic [AW-1:0] b_src, a0, b0, d_r, a1, b1, pre, b1_in;
   logic [PW-1:0] c_r, pcin_v, x, z, p_r;
   logic [MW-1:0] prod, m_r;
   logic          cin_src, cin;
   logic [PW:0]   sum;
   logic          cyo;

   // Cascade inputs, carry source and reset type are configuration-only in some builds.
   logic unused_cfg;
   assign unused_cfg = ^{PCIN, BCIN, CARRYIN, RSTTYPE == "SYNC", B_INPUT == "CASCADE"};

`ifdef DSP_CASCADE_EN
   assign b_src  = (B_INPUT == "CASCADE") ? BCIN : B;
   assign pcin_v = PCIN;
   assign PCOUT  = p_r;
   assign BCOUT  = b1;
`else
   assign b_src  = B;
   assign pcin_v = '0;
   assign PCOUT  = '0;
   assign BCOUT  = '0;
`endif

   dsp_reg_mux #(.W(8),  .REG(OPMODEREG)) u_opm (.clk(CLK), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opm));
   dsp_reg_mux #(.W(AW), .REG(DREG))      u_d   (.clk(CLK), .rst(RSTD), .ce(CED), .d(D),     .q(d_r));
   dsp_reg_mux #(.W(AW), .REG(A0REG))     u_a0  (.clk(CLK), .rst(RSTA), .ce(CEA), .d(A),     .q(a0));
   dsp_reg_mux #(.W(AW), .REG(B0REG))     u_b0  (.clk(CLK), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0));
   dsp_reg_mux #(.W(PW), .REG(CREG))      u_c   (.clk(CLK), .rst(RSTC), .ce(CEC), .d(C),     .q(c_r));

   assign pre   = opm[OP_PRESUB] ? (d_r - b0) : (d_r + b0);
   assign b1_in = opm[OP_PREADD] ? pre : b0;

   dsp_reg_mux #(.W(AW), .REG(A1REG)) u_a1 (.clk(CLK), .rst(RSTA), .ce(CEA), .d(a0),    .q(a1));
   dsp_reg_mux #(.W(AW), .REG(B1REG)) u_b1 (.clk(CLK), .rst(RSTB), .ce(CEB), .d(b1_in), .q(b1));

   assign prod = {{(MW-AW){1'b0}}, a1} * {{(MW-AW){1'b0}}, b1};

   dsp_reg_mux #(.W(MW), .REG(MREG)) u_m (.clk(CLK), .rst(RSTM), .ce(CEM), .d(prod), .q(m_r));

   assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : opm[OP_CINSEL];

   dsp_reg_mux #(.W(1), .REG(CARRYINREG)) u_cyi (.clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin));

   always_comb begin
      x = '0;
      case (xsel_e'(opm[OP_XSEL_LO +: 2]))
         X_ZERO: x = '0;
         X_M:    x = {{(PW-MW){1'b0}}, m_r};
         X_P:    x = p_r;
         X_DAB:  x = {d_r[11:0], a1, b1};
         default: x = '0;
      endcase
   end

   always_comb begin
      z = '0;
      case (zsel_e'(opm[OP_ZSEL_LO +: 2]))
         Z_ZERO: z = '0;
         Z_PCIN: z = pcin_v;
         Z_P:    z = p_r;
         Z_C:    z = c_r;
         default: z = '0;
      endcase
   end

   // 49-bit post-adder; bit 48 is the carry (or borrow) out.
   always_comb begin
      if (opm[OP_POSTSUB])
         sum = {1'b0, z} - ({1'b0, x} + {{PW{1'b0}}, cin});
      else
         sum = {1'b0, z} + {1'b0, x} + {{PW{1'b0}}, cin};
   end

   dsp_reg_mux #(.W(PW), .REG(PREG))        u_p   (.clk(CLK), .rst(RSTP), .ce(CEP), .d(sum[PW-1:0]), .q(p_r));
   dsp_reg_mux #(.W(1),  .REG(CARRYOUTREG)) u_cyo (.clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(sum[PW]), .q(cyo));

   assign M         = m_r;
   assign P         = p_r;
   assign CARRYOUT  = cyo;
   assign CARRYOUTF = cyo;
endmodule

// File: tb/tb_dsp.sv
// Directed-vector bench for dsp: stimulus pushes expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dsp;
`ifdef DSP_CASCADE_EN
   localparam bit CASC = 1'b1;
`else
   localparam bit CASC = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic [7:0]  OPMODE;
   logic        CEA, CEB, CEC, CECARRYIN, CED, CEM, CEP, CEOPMODE;
   logic        RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTP, RSTOPMODE;
   logic [17:0] A, B, D, BCIN;
   logic [47:0] C, PCIN;
   logic        CARRYIN;
   logic [35:0] M;
   logic [47:0] P, PCOUT;
   logic        CARRYOUT, CARRYOUTF;
   logic [17:0] BCOUT;

   typedef struct packed {
      logic [35:0] m;
      logic [47:0] p;
      logic [47:0] pc;
      logic        co;
      logic [17:0] bc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   dsp dut (
      .CLK(CLK), .OPMODE(OPMODE),
      .CEA(CEA), .CEB(CEB), .CEC(CEC), .CECARRYIN(CECARRYIN), .CED(CED), .CEM(CEM), .CEP(CEP), .CEOPMODE(CEOPMODE),
      .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTCARRYIN(RSTCARRYIN), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP), .RSTOPMODE(RSTOPMODE),
      .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .BCIN(BCIN),
      .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF), .BCOUT(BCOUT)
   );

   // clock
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("M",         {12'b0, M},       {12'b0, mon_e.m});
         chk("P",         P,                mon_e.p);
         chk("PCOUT",     PCOUT,            mon_e.pc);
         chk("CARRYOUT",  {47'b0, CARRYOUT},  {47'b0, mon_e.co});
         chk("CARRYOUTF", {47'b0, CARRYOUTF}, {47'b0, mon_e.co});
         chk("BCOUT",     {30'b0, BCOUT},   {30'b0, mon_e.bc});
      end
   end

   task automatic push_exp(input logic [35:0] em, input logic [47:0] ep, input logic eco, input logic [17:0] ebc);
      exp_t e;
      e.m  = em;
      e.p  = ep;
      e.pc = CASC ? ep : 48'd0;
      e.co = eco;
      e.bc = CASC ? ebc : 18'd0;
      exp_q.push_back(e);
   endtask

   task automatic set_all(input logic rst, input logic ce);
      {RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTP, RSTOPMODE} = {8{rst}};
      {CEA, CEB, CEC, CECARRYIN, CED, CEM, CEP, CEOPMODE} = {8{ce}};
   endtask

   // driver: apply one vector, hold 5 edges, then post the expected outputs
   task automatic run_case(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                           input logic [47:0] c, input logic [7:0] op,
                           input logic [35:0] em, input logic [47:0] ep, input logic eco, input logic [17:0] ebc);
      A = a; B = b; D = d; C = c; OPMODE = op;
      repeat (5) @(posedge CLK);
      #1;
      push_exp(em, ep, eco, ebc);
      @(negedge CLK);
      #1;
   endtask

   logic [47:0] p_m;
   logic        co_m;

   initial begin
      set_all(1'b1, 1'b0);
      OPMODE = 8'h00; A = '0; B = '0; D = '0; C = '0;
      PCIN = 48'd60; CARRYIN = 1'b0; BCIN = 18'd77;

      // all resets, one edge: everything observable is zero
      @(posedge CLK);
      #1;
      push_exp(36'd0, 48'd0, 1'b0, 18'd0);
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      #1;
      set_all(1'b0, 1'b1);

      // Z=PCIN minus M
      run_case(18'd10, 18'd5, 18'd3, 48'd0, 8'b1000_0101,
               36'd50, CASC ? 48'd10 : 48'hFFFF_FFFF_FFCE, CASC ? 1'b0 : 1'b1, 18'd5);
      // pre-subtract D-B, Z=C, carry-in 1
      run_case(18'd12, 18'd4, 18'd5, 48'd30, 8'b0111_1100, 36'd12, 48'd31, 1'b0, 18'd1);
      // post-subtract underflow
      run_case(18'd7, 18'd9, 18'd12, 48'd14, 8'b1111_1101, 36'd21, 48'hFFFF_FFFF_FFF8, 1'b1, 18'd3);
      // 0 - (0 + 1)
      run_case(18'd16, 18'd10, 18'd20, 48'd0, 8'b1110_0000, 36'd160, 48'hFFFF_FFFF_FFFF, 1'b1, 18'd10);
      run_case(18'd16, 18'd10, 18'd20, 48'd0, 8'b1111_0000, 36'd160, 48'hFFFF_FFFF_FFFF, 1'b1, 18'd10);

      // CEP/CEM low: P and M hold while operands and OPMODE change
      CEP = 1'b0; CEM = 1'b0;
      run_case(18'd3, 18'd10, 18'd20, 48'd0, 8'b0000_0001, 36'd160, 48'hFFFF_FFFF_FFFF, 1'b0, 18'd10);
      CEP = 1'b1; CEM = 1'b1;

      // X = {D[11:0], A, B}, pre-add into B1
      run_case(18'd16, 18'd10, 18'd20, 48'd5, 8'b0011_1111, 36'd480, 48'h140_0040_0024, 1'b0, 18'd30);

      // feedback accumulate: P <= 2P + 1
      p_m = 48'h140_0040_0024;
      OPMODE = 8'b0011_1010;
      @(posedge CLK);
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK);
         #1;
         co_m = p_m[47];
         p_m  = {p_m[46:0], 1'b1};
         push_exp(36'd480, p_m, co_m, 18'd30);
      end
      @(negedge CLK);
      #1;
      RSTP = 1'b1;
      @(posedge CLK);
      #1;
      push_exp(36'd480, 48'd0, p_m[47], 18'd30);
      @(negedge CLK);
      #1;
      RSTP = 1'b0;

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dsp.md
DSP -- requirements
Module: dsp

Interface
REQ-001 Parameters A0REG=0, B0REG=0: 1 registers the first A/B stage; 0 bypasses it combinationally.
REQ-002 Parameters A1REG, B1REG, CREG, DREG, MREG, PREG=1 each: 1 registers the stage; 0 bypasses it.
REQ-003 Parameters CARRYINREG, CARRYOUTREG, OPMODEREG=1 each: 1 registers the stage; 0 bypasses it.
REQ-004 Parameter CARRYINSEL="OPMODE5" selects carry-in source: "OPMODE5" uses OPMODE[5]; "CARRYIN" uses the CARRYIN port.
REQ-005 Parameter B_INPUT="DIRECT" selects B source: "DIRECT" uses port B; "CASCADE" uses BCIN.
REQ-006 Parameter RSTTYPE="SYNC": the only supported value.
REQ-007 Ports are positional in this exact order: CLK, OPMODE, CEA, CEB, CEC, CECARRYIN, CED, CEM, CEP, CEOPMODE, RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTP, RSTOPMODE, A, B, D, C, PCIN, CARRYIN, BCIN, M, P, PCOUT, CARRYOUT, CARRYOUTF, BCOUT.
REQ-008 CLK  in  1  sole clock; all registers update on its rising edge.
REQ-009 RSTA/RSTB/RSTC/RSTCARRYIN/RSTD/RSTM/RSTP/RSTOPMODE  in  1 each  synchronous, active-high reset of the matching register group.
REQ-010 CEA/CEB/CEC/CECARRYIN/CED/CEM/CEP/CEOPMODE  in  1 each  clock enable of the matching register group.
REQ-011 OPMODE  in  8  operation control; A, B, D  in  18 each  operands; C  in  48  adder operand.
REQ-012 PCIN  in  48  P cascade in; BCIN  in  18  B cascade in; CARRYIN  in  1  external carry.
REQ-013 M  out  36  product; P, PCOUT  out  48 each  result; CARRYOUT, CARRYOUTF  out  1 each  carry; BCOUT  out  18  B1 stage value.

Function
REQ-014 Every register stage: reset has priority over CE; CE=0 holds the value; bypassed stages (param=0) pass the input combinationally.
REQ-015 Pre-adder uses D-reg and B0-stage values: OPMODE[6]=0 computes D+B0, =1 computes D-B0, mod 2^18; OPMODE[4]=1 feeds the pre-adder result to B1, =0 feeds B0.
REQ-016 Multiplier: A1*B1 unsigned, 36 bits, into MREG; M = MREG output; BCOUT = B1 output.
REQ-017 X mux by OPMODE[1:0]: 00 gives 0; 01 gives M zero-extended; 10 gives P; 11 gives {D[11:0], A1, B1}.
REQ-018 Z mux by OPMODE[3:2]: 00 gives 0; 01 gives PCIN; 10 gives P; 11 gives C-reg value.
REQ-019 Carry-in per CARRYINSEL, through the CYI register (CECARRYIN/RSTCARRYIN).
REQ-020 Post-adder, 49-bit result: OPMODE[7]=0 computes Z+X+CIN; =1 computes Z-(X+CIN), mod 2^49.
REQ-021 Bits [47:0] go to PREG; bit 48 goes to the CYO register (CECARRYIN/RSTCARRYIN).
REQ-022 PCOUT=P; CARRYOUTF=CARRYOUT.
REQ-023 All OPMODE bits are taken from the OPMODE register when OPMODEREG=1.
REQ-024 Latency with default parameters: P is correct on the 4th rising edge after inputs and OPMODE become stable, and stays constant thereafter unless X/Z select P.

Reset
REQ-025 Asserting each RST* clears its group to 0 at the next rising edge.
REQ-026 With all resets asserted, after one edge M=0, P=0, PCOUT=0, BCOUT=0, CARRYOUT=0, CARRYOUTF=0.

Configuration
REQ-027 Macro DSP_CASCADE_EN: when defined, PCIN and BCIN behave as above; when undefined, Z=01 yields 0, B_INPUT is treated as "DIRECT", and PCOUT and BCOUT are driven 0. Benches define the macro.

Structure
REQ-028 Package dsp_pkg holds the width constants (18/36/48) and the OPMODE field positions and X/Z mux encodings.
REQ-029 One sub-module, dsp_reg_mux, implements each stage: width parameter, register-or-bypass, CE, synchronous reset.

Verification (default parameters; resets held 5 cycles, then all CE=1; each case held 5 cycles)
REQ-030 A=10, B=5, D=3, PCIN=60, OPMODE=8'b1000_0101 -> M=50, P=10, CARRYOUT=0.
REQ-031 A=12, B=4, D=5, C=30, OPMODE=8'b0111_1100 -> M=12 (D-B=1), P=31.
REQ-032 A=7, B=9, D=12, C=14, OPMODE=8'b1111_1101 -> M=21, P=48'hFFFF_FFFF_FFF8, CARRYOUT=1.
REQ-033 A=16, B=10, D=20, OPMODE=8'b1110_0000 -> M=160, P=48'hFFFF_FFFF_FFFF, CARRYOUT=1; with OPMODE[4]=1 -> M=160, P unchanged.
REQ-034 A=16, B=10, D=20, C=5, OPMODE=8'b0011_1111 -> BCOUT=30, P=48'h140_0040_0024.
REQ-035 OPMODE=8'b0011_1010 (X=P, Z=P, CIN=1) -> P becomes 2P+1 mod 2^48 each cycle; then RSTP=1 -> P=0 at the next edge.
